// File: rtl/osc_phase_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : osc_phase_gen                                          |
// | Description : Phase-accumulator oscillator. Advances a PHASE_W-bit   |
// |               phase by freq on every sample_tick and renders saw,    |
// |               square, triangle or silence through a 2-stage pipe.    |
// |               Emits a wrap pulse on accumulator carry for hard sync. |
// |               Optional sub-octave square enabled by OSC_SUB_OSC_EN.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module osc_phase_gen #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               sample_tick,
  input  logic [PHASE_W-1:0] freq,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] pulse_width,
  input  logic               sync,
  output logic [OUT_W-1:0]   sample,
  output logic               sample_valid,
  output logic               wrap,
  output logic [OUT_W-1:0]   sub_out
);

  localparam logic [1:0] WAVE_SAW    = 2'b00;
  localparam logic [1:0] WAVE_SQUARE = 2'b01;
  localparam logic [1:0] WAVE_TRI    = 2'b10;

  localparam logic [OUT_W-1:0] FULL_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] FULL_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  // Stage-1 state: accumulator plus the controls captured with each tick
  logic [PHASE_W-1:0] phase;
  logic               s1_valid;
  logic [1:0]         s1_wave;
  logic [PHASE_W-1:0] s1_pw;

  // Carry-extended sum so the top bit is the wrap indication
  logic [PHASE_W:0]   sum;
  assign sum = {1'b0, phase} + {1'b0, freq};

  // Stage 1: accumulate on tick; sync restarts the phase from zero
  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase    <= '0;
      wrap     <= 1'b0;
      s1_valid <= 1'b0;
      s1_wave  <= 2'b00;
      s1_pw    <= '0;
    end else begin
      s1_valid <= sample_tick;
      if (sample_tick) begin
        s1_wave <= wave_sel;
        s1_pw   <= pulse_width;
        if (sync) begin
          // Restart at zero then add this tick's increment
          phase <= freq;
          wrap  <= 1'b1;
        end else begin
          phase <= sum[PHASE_W-1:0];
          wrap  <= sum[PHASE_W];
        end
      end else begin
        wrap <= 1'b0;
        if (sync) begin
          phase <= '0;
        end
      end
    end
  end

  // Triangle folds the upper half of the cycle back down
  logic [PHASE_W-2:0] tri_fold;
  logic [OUT_W-1:0]   wave_val;

  // Stage-2 waveform shaping from the stage-1 phase and latched controls
  always_comb begin
    wave_val = '0;
    tri_fold = phase[PHASE_W-1] ? ~phase[PHASE_W-2:0] : phase[PHASE_W-2:0];
    case (s1_wave)
      WAVE_SAW:    wave_val = {~phase[PHASE_W-1], phase[PHASE_W-2:PHASE_W-OUT_W]};
      WAVE_SQUARE: wave_val = (phase < s1_pw) ? FULL_POS : FULL_NEG;
      WAVE_TRI:    wave_val = {~tri_fold[PHASE_W-2], tri_fold[PHASE_W-3:PHASE_W-OUT_W-1]};
      default:     wave_val = '0;
    endcase
  end

  // Stage 2: register the shaped sample and its valid strobe
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= s1_valid;
      if (s1_valid) begin
        sample <= wave_val;
      end
    end
  end

`ifdef OSC_SUB_OSC_EN
  logic sub_toggle;

  // Sub toggle halves the wrap rate; sync realigns it to the new cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sub_toggle <= 1'b0;
    end else if (sync) begin
      sub_toggle <= 1'b0;
    end else if (sample_tick && sum[PHASE_W]) begin
      sub_toggle <= ~sub_toggle;
    end
  end

  // Sub output advances in lockstep with the main sample
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sub_out <= '0;
    end else if (s1_valid) begin
      sub_out <= sub_toggle ? FULL_POS : FULL_NEG;
    end
  end
`else
  assign sub_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_osc_phase_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_osc_phase_gen                                       |
// | Description : Scoreboard bench for osc_phase_gen: directed sequences |
// |               followed by random ticks/sync/reset against an         |
// |               arithmetic reference model. Honours OSC_SUB_OSC_EN.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_osc_phase_gen;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        sample_tick = 1'b0;
  logic [23:0] freq = '0;
  logic [1:0]  wave_sel = 2'b00;
  logic [23:0] pulse_width = '0;
  logic        sync = 1'b0;
  logic [15:0] sample;
  logic        sample_valid;
  logic        wrap;
  logic [15:0] sub_out;

  osc_phase_gen #(.PHASE_W(24), .OUT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .sample_tick(sample_tick), .freq(freq),
    .wave_sel(wave_sel), .pulse_width(pulse_width), .sync(sync),
    .sample(sample), .sample_valid(sample_valid), .wrap(wrap), .sub_out(sub_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] s;
    logic [15:0] sub;
  } exp_t;

  exp_t sq[$];
  bit   wq[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint unsigned m_phase = 0;
  bit              m_tog = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_wave(input longint unsigned ph, input logic [1:0] ws,
                                           input longint unsigned pw);
    longint unsigned t;
    case (ws)
      2'd0: return 16'((ph >> 8) ^ 64'h8000);
      2'd1: return (ph < pw) ? 16'h7FFF : 16'h8000;
      2'd2: begin
        t = (ph >= 64'h800000) ? (64'h7FFFFF - (ph - 64'h800000)) : ph;
        return 16'((t >> 7) ^ 64'h8000);
      end
      default: return 16'h0000;
    endcase
  endfunction

  // Drive one cycle of inputs and record what the model predicts for it
  task automatic step(input bit tk, input bit sy, input bit rs, input logic [23:0] f,
                      input logic [1:0] ws, input logic [23:0] pw);
    longint unsigned s;
    bit w;
    exp_t e;
    @(negedge CLK);
    #1;
    sample_tick = tk; sync = sy; RESET = rs;
    freq = f; wave_sel = ws; pulse_width = pw;
    w = 0;
    if (rs) begin
      m_phase = 0; m_tog = 0;
      sq.delete();
    end else if (tk) begin
      s = m_phase + longint'(f);
      if (sy) begin
        m_phase = longint'(f); w = 1; m_tog = 0;
      end else begin
        m_phase = s % (64'd1 << 24);
        w = (s >= (64'd1 << 24));
        if (w) m_tog = ~m_tog;
      end
      e.s = ref_wave(m_phase, ws, longint'(pw));
`ifdef OSC_SUB_OSC_EN
      e.sub = m_tog ? 16'h7FFF : 16'h8000;
`else
      e.sub = 16'h0000;
`endif
      sq.push_back(e);
    end else if (sy) begin
      m_phase = 0; m_tog = 0;
    end
    wq.push_back(w);
  endtask

  // Non-tick cycles carry random controls that must be ignored by the DUT
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 24'($urandom), 2'($urandom), 24'($urandom));
  endtask

  task automatic tick(input logic [23:0] f, input logic [1:0] ws, input logic [23:0] pw);
    step(1, 0, 0, f, ws, pw);
  endtask

  task automatic do_reset;
    step(0, 0, 1, '0, 2'b00, '0);
    step(0, 0, 1, '0, 2'b00, '0);
  endtask

  // Outputs after a reset edge must all be zero
  task automatic chk_idle(input string tag);
    @(negedge CLK);
    #2;
    chk({tag, "_sample"}, 32'(sample), 32'h0);
    chk({tag, "_valid"}, 32'(sample_valid), 32'h0);
    chk({tag, "_wrap"}, 32'(wrap), 32'h0);
    chk({tag, "_sub"}, 32'(sub_out), 32'h0);
  endtask

  // Monitor: wrap checked every driven cycle, samples popped on valid
  initial begin
    bit   w;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (wq.size() > 0) begin
        w = wq.pop_front();
        chk("wrap", 32'(wrap), 32'(w));
      end
      if (sample_valid === 1'b1) begin
        if (sq.size() == 0) begin
          chk("unexpected_valid", 32'(sample_valid), 32'h0);
        end else begin
          e = sq.pop_front();
          chk("sample", 32'(sample), 32'(e.s));
          chk("sub_out", 32'(sub_out), 32'(e.sub));
        end
      end
    end
  end

  initial begin
    // 1: reset state, then first saw sample
    do_reset();
    chk_idle("reset");
    tick(24'h100000, 2'b00, '0);
    idle(3);

    // 2: half-cycle increment, ticks spaced apart, wrap on second tick
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(24'h800000, 2'b00, '0);
      idle(3);
    end

    // 3: square at 50% duty
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(24'h400000, 2'b01, 24'h800000);
      idle(1);
    end
    tick(24'h400000, 2'b01, 24'h000000);
    idle(2);

    // 4: triangle corners
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(24'h200000, 2'b10, '0);
      idle(1);
    end
    tick(24'h1FFFFF, 2'b10, '0);
    tick(24'h0, 2'b11, '0);
    idle(3);

    // 5: back-to-back ticks
    do_reset();
    for (int i = 0; i < 3; i++) tick(24'h100000, 2'b00, '0);
    idle(3);

    // 6: sync alone, sync with tick, reset discarding an in-flight tick
    do_reset();
    tick(24'h600000, 2'b00, '0);
    idle(2);
    step(0, 1, 0, 24'h0, 2'b00, '0);
    idle(1);
    tick(24'h123456, 2'b00, '0);
    idle(2);
    step(1, 1, 0, 24'h0ABCDE, 2'b00, '0);
    idle(2);
    tick(24'h100000, 2'b00, '0);
    step(0, 0, 1, '0, 2'b00, '0);
    chk_idle("reset_inflight");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [23:0] f;
      f = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 255)) : 24'($urandom);
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 299) == 0), f, 2'($urandom), 24'($urandom));
    end
    idle(4);
    #2;
    chk("queue_drained", 32'(sq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
